// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for branch resolution: tracking entry layout,
// redirect reasons and sequential-PC helper.
package branch_resolve_unit_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            pred;
    logic [XLEN-1:0] pred_target;
  } track_entry_t;

  // Why the EX branch redirected fetch (debug visibility only)
  typedef enum logic [1:0] {
    RR_NONE   = 2'd0,
    RR_DIR_T  = 2'd1,  // predicted not taken, actually taken
    RR_DIR_NT = 2'd2,  // predicted taken, actually not taken
    RR_TARGET = 2'd3   // taken as predicted, but to a different target
  } redirect_reason_e;

  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch-side, EX-side and redirect/counter signals of the branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int unsigned CNT_W = 32
);
  import branch_resolve_unit_pkg::*;

  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic            if_is_branch;
  logic            if_prediction;
  logic [XLEN-1:0] if_pred_target;
  logic            stall;
  logic            ex_branch;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;

  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush;
  logic             pred_update;
  logic             pred_outcome;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output if_valid, if_pc, if_is_branch, if_prediction, if_pred_target,
           stall, ex_branch, ex_taken, ex_target,
    input  mispredict, redirect_pc, flush, pred_update, pred_outcome,
           branch_count, mispredict_count
  );

  modport slave (
    input  if_valid, if_pc, if_is_branch, if_prediction, if_pred_target,
           stall, ex_branch, ex_taken, ex_target,
    output mispredict, redirect_pc, flush, pred_update, pred_outcome,
           branch_count, mispredict_count
  );

endinterface

// File: rtl/branch_resolve_unit_track_stage.sv
// One pipeline tracking register for a fetched instruction's prediction;
// clear drops the valid bit and dominates hold.
module branch_track_stage
  import branch_resolve_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         clear,
  input  track_entry_t entry_i,
  output track_entry_t entry_o
);

  track_entry_t entry_d, entry_q;

  always_comb begin
    entry_d = entry_q;
    if (clear) begin
      entry_d.valid = 1'b0;
    end else if (!hold) begin
      entry_d = entry_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks each fetched instruction's prediction through IF/ID and ID/EX,
// resolves it in EX, drives redirect/flush, predictor update and perf counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus
);

  track_entry_t     cap_c;
  track_entry_t     s1_q;
  track_entry_t     s2_q;
  logic             res_c;
  logic             mispredict_c;
  logic [XLEN-1:0]  redirect_c;
  redirect_reason_e reason_c;
  logic [CNT_W-1:0] branch_count_d, branch_count_q;
  logic [CNT_W-1:0] mispredict_count_d, mispredict_count_q;

  // Non-branches never carry a taken prediction; fall-through is the target
  always_comb begin
    cap_c             = '0;
    cap_c.valid       = bus.if_valid;
    cap_c.pc          = bus.if_pc;
    cap_c.pred        = bus.if_prediction & bus.if_is_branch;
    cap_c.pred_target = cap_c.pred ? bus.if_pred_target : next_seq_pc(bus.if_pc);
  end

  branch_track_stage u_s1 (
    .clk     (clk),
    .rst     (rst),
    .hold    (bus.stall),
    .clear   (mispredict_c),
    .entry_i (cap_c),
    .entry_o (s1_q)
  );

  branch_track_stage u_s2 (
    .clk     (clk),
    .rst     (rst),
    .hold    (1'b0),
    .clear   (mispredict_c | bus.stall),
    .entry_i (s1_q),
    .entry_o (s2_q)
  );

  // Only a valid ID/EX slot may resolve; bubbles and flushed slots are ignored
  always_comb begin
    res_c      = bus.ex_branch & s2_q.valid;
    reason_c   = RR_NONE;
    redirect_c = '0;
    if (res_c) begin
      if (!s2_q.pred && bus.ex_taken) begin
        reason_c   = RR_DIR_T;
        redirect_c = bus.ex_target;
      end else if (s2_q.pred && !bus.ex_taken) begin
        reason_c   = RR_DIR_NT;
        redirect_c = next_seq_pc(s2_q.pc);
      end else if (s2_q.pred && bus.ex_taken && (bus.ex_target != s2_q.pred_target)) begin
        reason_c   = RR_TARGET;
        redirect_c = bus.ex_target;
      end
    end
    mispredict_c = (reason_c != RR_NONE);
  end

  // Saturating performance counters
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (res_c && (branch_count_q != {CNT_W{1'b1}})) begin
      branch_count_d = branch_count_q + CNT_W'(1);
    end
    if (mispredict_c && (mispredict_count_q != {CNT_W{1'b1}})) begin
      mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign bus.mispredict       = mispredict_c;
  assign bus.redirect_pc      = redirect_c;
  assign bus.flush            = mispredict_c;
  assign bus.pred_update      = res_c;
  assign bus.pred_outcome     = bus.ex_taken & res_c;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit; a second narrow-counter
// instance shares the stimulus to exercise counter saturation.
module tb_branch_resolve_unit;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  branch_resolve_unit_if #(.CNT_W(32)) bus ();
  branch_resolve_unit_if #(.CNT_W(2))  sbus ();

  branch_resolve_unit #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  branch_resolve_unit #(.CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus.slave)
  );

  assign sbus.if_valid       = bus.if_valid;
  assign sbus.if_pc          = bus.if_pc;
  assign sbus.if_is_branch   = bus.if_is_branch;
  assign sbus.if_prediction  = bus.if_prediction;
  assign sbus.if_pred_target = bus.if_pred_target;
  assign sbus.stall          = bus.stall;
  assign sbus.ex_branch      = bus.ex_branch;
  assign sbus.ex_taken       = bus.ex_taken;
  assign sbus.ex_target      = bus.ex_target;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [31:0] pc, input logic isbr,
                       input logic pred, input logic [31:0] tgt);
    bus.if_valid       = v;
    bus.if_pc          = pc;
    bus.if_is_branch   = isbr;
    bus.if_prediction  = pred;
    bus.if_pred_target = tgt;
  endtask

  task automatic set_ex(input logic br, input logic tk, input logic [31:0] tgt);
    bus.ex_branch = br;
    bus.ex_taken  = tk;
    bus.ex_target = tgt;
  endtask

  // Fetch a branch, let it travel two stall-free cycles, present EX outcome
  task automatic issue(input logic [31:0] pc, input logic isbr, input logic pred,
                       input logic [31:0] ptgt, input logic tk, input logic [31:0] etgt);
    fetch(1'b1, pc, isbr, pred, ptgt);
    set_ex(1'b0, 1'b0, 32'h0);
    tick();
    fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    set_ex(1'b1, tk, etgt);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic mp, input logic [31:0] rpc,
                          input logic upd, input logic outc);
    chk_eq({tag, ".mispredict"}, 32'(bus.mispredict), 32'(mp));
    chk_eq({tag, ".redirect_pc"}, bus.redirect_pc, rpc);
    chk_eq({tag, ".flush"}, 32'(bus.flush), 32'(mp));
    chk_eq({tag, ".pred_update"}, 32'(bus.pred_update), 32'(upd));
    chk_eq({tag, ".pred_outcome"}, 32'(bus.pred_outcome), 32'(outc));
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] bc, input logic [31:0] mc);
    chk_eq({tag, ".branch_count"}, bus.branch_count, bc);
    chk_eq({tag, ".mispredict_count"}, bus.mispredict_count, mc);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.stall = 1'b0;
    fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    set_ex(1'b0, 1'b0, 32'h0);
    tick();
    tick();

    // Reset state, with ex_branch asserted to show nothing resolves
    set_ex(1'b1, 1'b1, 32'h1234);
    #1;
    chk_outs("reset", 1'b0, 32'h0, 1'b0, 1'b0);
    chk_cnt("reset", 32'd0, 32'd0);
    set_ex(1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    tick();

    // Predicted not taken, actually taken
    issue(32'h100, 1'b1, 1'b0, 32'h999, 1'b1, 32'h140);
    chk_outs("nt_taken", 1'b1, 32'h140, 1'b1, 1'b1);
    fetch(1'b1, 32'h104, 1'b1, 1'b1, 32'h500);  // wrong-path fetch, must be flushed
    tick();
    fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk_cnt("nt_taken", 32'd1, 32'd1);
    chk_eq("sat_after_one.branch_count", 32'(sbus.branch_count), 32'd1);
    #1;
    chk_outs("post_flush0", 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_outs("post_flush1", 1'b0, 32'h0, 1'b0, 1'b0);
    set_ex(1'b0, 1'b0, 32'h0);
    tick();

    // Predicted taken, actually not taken -> fall-through
    issue(32'h200, 1'b1, 1'b1, 32'h180, 1'b0, 32'h180);
    chk_outs("t_nt", 1'b1, 32'h204, 1'b1, 1'b0);
    tick();
    chk_cnt("t_nt", 32'd2, 32'd2);

    // Same branch, correctly predicted taken with matching target
    issue(32'h200, 1'b1, 1'b1, 32'h180, 1'b1, 32'h180);
    chk_outs("t_t_ok", 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    chk_cnt("t_t_ok", 32'd3, 32'd2);

    // Taken as predicted but to a different target
    issue(32'h2f0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h310);
    chk_outs("tgt_miss", 1'b1, 32'h310, 1'b1, 1'b1);
    tick();
    chk_cnt("tgt_miss", 32'd4, 32'd3);

    // Fall-through PC wraps modulo 2^32
    issue(32'hffff_fffc, 1'b1, 1'b1, 32'h40, 1'b0, 32'h40);
    chk_outs("pc_wrap", 1'b1, 32'h0, 1'b1, 1'b0);
    tick();
    chk_cnt("pc_wrap", 32'd5, 32'd4);

    // Non-branch with predictor saying taken: stored pred must be 0
    issue(32'h400, 1'b0, 1'b1, 32'h800, 1'b0, 32'h800);
    chk_outs("nonbr", 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk_cnt("nonbr", 32'd6, 32'd4);

    // Two stall cycles: bubbles in S2 never resolve, branch resolves once
    fetch(1'b1, 32'h500, 1'b1, 1'b1, 32'h540);
    set_ex(1'b0, 1'b0, 32'h0);
    tick();
    fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    bus.stall = 1'b1;
    set_ex(1'b1, 1'b1, 32'h540);
    #1;
    chk_outs("stall_c1", 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_outs("stall_c2", 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    bus.stall = 1'b0;
    #1;
    chk_outs("stall_bubble", 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_outs("stall_resolve", 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    chk_cnt("stall", 32'd7, 32'd4);
    set_ex(1'b0, 1'b0, 32'h0);

    // Mispredict during a stall: S1 must be cleared, not held
    fetch(1'b1, 32'h600, 1'b1, 1'b0, 32'h0);
    tick();
    fetch(1'b1, 32'h700, 1'b1, 1'b0, 32'h0);
    tick();
    fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    bus.stall = 1'b1;
    set_ex(1'b1, 1'b1, 32'h640);
    #1;
    chk_outs("mp_stall", 1'b1, 32'h640, 1'b1, 1'b1);
    tick();
    bus.stall = 1'b0;
    set_ex(1'b0, 1'b0, 32'h0);
    tick();
    set_ex(1'b1, 1'b0, 32'h0);
    #1;
    chk_outs("mp_stall_s1_cleared", 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    set_ex(1'b0, 1'b0, 32'h0);
    chk_cnt("mp_stall", 32'd8, 32'd5);
    chk_eq("sat.branch_count", 32'(sbus.branch_count), 32'd3);
    chk_eq("sat.mispredict_count", 32'(sbus.mispredict_count), 32'd3);

    // Reset mid-stream with a live mispredict
    fetch(1'b1, 32'h800, 1'b1, 1'b0, 32'h0);
    tick();
    fetch(1'b1, 32'h804, 1'b1, 1'b0, 32'h0);
    tick();
    set_ex(1'b1, 1'b1, 32'h880);
    #1;
    chk_outs("pre_rst", 1'b1, 32'h880, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk_outs("mid_rst", 1'b0, 32'h0, 1'b0, 1'b0);
    chk_cnt("mid_rst", 32'd0, 32'd0);
    chk_eq("mid_rst.sat_branch_count", 32'(sbus.branch_count), 32'd0);
    tick();
    fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    set_ex(1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    tick();

    issue(32'h900, 1'b1, 1'b1, 32'h940, 1'b0, 32'h940);
    chk_outs("post_rst", 1'b1, 32'h904, 1'b1, 1'b0);
    tick();
    set_ex(1'b0, 1'b0, 32'h0);
    chk_cnt("post_rst", 32'd1, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
